// File: rtl/apple2_disk_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | apple2_disk_pkg : shared disk geometry, loader state type, helper   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package apple2_disk_pkg;

   localparam int unsigned SECTORS_PER_TRACK = 13;
   localparam int unsigned TRACK_BYTES       = 6656;
   localparam int unsigned TRK_W             = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      LOAD  = 2'd2
   } dtl_state_t;

   // First image sector of a track.
   function automatic logic [31:0] track_lba(input int unsigned sectors, input logic [31:0] trk);
      return sectors * trk;
   endfunction

endpackage
`default_nettype wire

// File: rtl/disk_track_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | disk_track_loader : whole-track load / write-back between the SD    |
// | block interface and drive track RAM.   Revision 1.0                 |
// +--------------------------------------------------------------------+
module disk_track_loader
   import apple2_disk_pkg::*;
#(
   parameter int unsigned SECTORS = SECTORS_PER_TRACK,
   parameter int unsigned TRK_W   = apple2_disk_pkg::TRK_W
)(
   input  logic             clk_sys,
   input  logic             reset,
   input  logic [TRK_W-1:0] track,
   input  logic             track_we,
   input  logic             img_mounted,
   input  logic             img_readonly,
   input  logic [63:0]      img_size,
   output logic [31:0]      sd_lba,
   output logic             sd_rd,
   output logic             sd_wr,
   input  logic             sd_ack,
   output logic [3:0]       track_sec,
   output logic             cpu_wait,
   output logic             busy
);

   localparam logic [3:0] c_last_sec = 4'(SECTORS - 1);

   dtl_state_t       r_state, w_state;
   logic [TRK_W-1:0] r_cur_track, w_cur_track;
   logic             r_loaded, w_loaded;
   logic             r_dirty, w_dirty;
   logic             r_remount, w_remount;
   logic             r_old_ack;
   logic [31:0]      w_lba;
   logic             w_rd, w_wr, w_wait;
   logic [3:0]       w_sec;
   logic             w_start_load, w_start_flush;

   wire w_rise = ~r_old_ack & sd_ack;
   wire w_fall = r_old_ack & ~sd_ack;

   assign busy = (r_state != IDLE);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cur_track <= '0;
         r_loaded    <= 1'b0;
         r_dirty     <= 1'b0;
         r_remount   <= 1'b0;
         r_old_ack   <= 1'b0;
         sd_lba      <= 32'd0;
         sd_rd       <= 1'b0;
         sd_wr       <= 1'b0;
         track_sec   <= 4'd0;
         cpu_wait    <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cur_track <= w_cur_track;
         r_loaded    <= w_loaded;
         r_dirty     <= w_dirty;
         r_remount   <= w_remount;
         r_old_ack   <= sd_ack;
         sd_lba      <= w_lba;
         sd_rd       <= w_rd;
         sd_wr       <= w_wr;
         track_sec   <= w_sec;
         cpu_wait    <= w_wait;
      end
   end

   always_comb begin
      w_state       = r_state;
      w_cur_track   = r_cur_track;
      w_loaded      = r_loaded;
      w_dirty       = r_dirty;
      w_remount     = r_remount;
      w_lba         = sd_lba;
      w_rd          = sd_rd;
      w_wr          = sd_wr;
      w_sec         = track_sec;
      w_wait        = cpu_wait;
      w_start_load  = 1'b0;
      w_start_flush = 1'b0;

      case (r_state)
         IDLE: begin
            if (track_we)
               w_dirty = 1'b1;
            if (img_size == 64'd0)
               w_loaded = 1'b0;
            else if (r_remount) begin
               // Old RAM content belongs to the previous image: never flush it.
               w_remount    = 1'b0;
               w_dirty      = 1'b0;
               w_start_load = 1'b1;
            end else if (!r_loaded || (track != r_cur_track)) begin
               if (r_dirty && !img_readonly && r_loaded)
                  w_start_flush = 1'b1;
               else begin
                  w_dirty      = 1'b0;
                  w_start_load = 1'b1;
               end
            end
         end
         FLUSH, LOAD: begin
            if (w_rise) begin
               w_lba = sd_lba + 32'd1;
               if (track_sec == c_last_sec) begin
                  w_rd = 1'b0;
                  w_wr = 1'b0;
               end
            end
            if (w_fall) begin
               w_sec = track_sec + 4'd1;
               // Request already dropped: this was the last sector.
               if (!sd_rd && !sd_wr) begin
                  if (r_state == FLUSH) begin
                     w_dirty      = 1'b0;
                     w_start_load = 1'b1;
                  end else begin
                     w_loaded = 1'b1;
                     w_wait   = 1'b0;
                     w_state  = IDLE;
                  end
               end
            end
         end
         default: w_state = IDLE;
      endcase

      if (img_mounted)
         w_remount = 1'b1;

      if (w_start_flush) begin
         w_state = FLUSH;
         w_lba   = track_lba(SECTORS, 32'(r_cur_track));
         w_sec   = 4'd0;
         w_rd    = 1'b0;
         w_wr    = 1'b1;
         w_wait  = 1'b1;
      end

      if (w_start_load) begin
         w_state     = LOAD;
         w_lba       = track_lba(SECTORS, 32'(track));
         w_sec       = 4'd0;
         w_rd        = 1'b1;
         w_wr        = 1'b0;
         w_wait      = 1'b1;
         w_cur_track = track;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_disk_track_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_disk_track_loader : scoreboard bench for disk_track_loader       |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_disk_track_loader;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  track = '0;
   logic        track_we = 1'b0;
   logic        img_mounted = 1'b0;
   logic        img_readonly = 1'b0;
   logic [63:0] img_size = 64'd0;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr;
   logic        sd_ack = 1'b0;
   logic [3:0]  track_sec;
   logic        cpu_wait, busy;

   typedef struct packed {
      logic        wr;
      logic [31:0] lba;
      logic [3:0]  sec;
   } sect_t;

   sect_t sb[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;

   disk_track_loader #(.SECTORS(13), .TRK_W(6)) dut (
      .clk_sys(clk_sys), .reset(reset), .track(track), .track_we(track_we),
      .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .track_sec(track_sec), .cpu_wait(cpu_wait), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   initial forever begin
      @(posedge clk_sys);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_track(input logic wr, input int unsigned base, input int n);
      for (int i = 0; i < n; i++)
         sb.push_back('{wr: wr, lba: 32'(base + i), sec: 4'(i)});
   endtask

   // hps_io model: 4-cycle ack per sector, 2-cycle gap.
   initial forever begin
      @(posedge clk_sys);
      #1;
      if (sd_rd | sd_wr) begin
         sd_ack = 1'b1;
         repeat (4) @(posedge clk_sys);
         #1;
         sd_ack = 1'b0;
         repeat (2) @(posedge clk_sys);
      end
   end

   // Monitor: each ack rise is one sector transaction.
   initial begin : monitor
      logic pa;
      sect_t got, exp;
      pa = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (!reset) begin
            check("rd_wr_exclusive", {63'd0, sd_rd & sd_wr}, 64'd0);
            if (sd_ack && !pa) begin
               got = '{wr: sd_wr, lba: sd_lba, sec: track_sec};
               if (sb.size() == 0)
                  check("unexpected_sector", 64'(got), 64'h1_0000_0000_0);
               else begin
                  exp = sb.pop_front();
                  check("sector", 64'(got), 64'(exp));
               end
            end
         end
         pa = sd_ack;
      end
   end

   task automatic wait_done(input logic exp_wr, input bit chk_q, input string name);
      int n;
      bit gap, saw_wr, prev;
      int last_fall;
      n = 0; gap = 0; saw_wr = 0; prev = 0; last_fall = 0;
      while (!busy && n < 50) begin
         @(negedge clk_sys);
         n++;
      end
      check({name, "_start"}, {63'd0, busy}, 64'd1);
      if (!busy) return;
      check({name, "_req_and_wait"}, {62'd0, sd_rd | sd_wr, cpu_wait}, 64'd3);
      n = 0;
      while (busy && n < 3000) begin
         if (!cpu_wait) gap = 1;
         if (sd_wr) saw_wr = 1;
         if (prev && !sd_ack) last_fall = cyc;
         prev = sd_ack;
         @(negedge clk_sys);
         n++;
      end
      check({name, "_done"}, {63'd0, busy}, 64'd0);
      check({name, "_wait_gap"}, {63'd0, gap}, 64'd0);
      check({name, "_saw_wr"}, {63'd0, saw_wr}, {63'd0, exp_wr});
      check({name, "_wait_fall_lat"}, 64'(cyc - last_fall), 64'd1);
      check({name, "_cpu_wait"}, {63'd0, cpu_wait}, 64'd0);
      check({name, "_loaded"}, {63'd0, dut.r_loaded}, 64'd1);
      if (chk_q) check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic goto_track(input logic [5:0] t, input string name);
      push_track(1'b0, 13 * t, 13);
      track = t;
      wait_done(1'b0, 1'b1, name);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk_sys);
      check("rst_lba", 64'(sd_lba), 64'd0);
      check("rst_rd_wr", {62'd0, sd_rd, sd_wr}, 64'd0);
      check("rst_sec", 64'(track_sec), 64'd0);
      check("rst_wait_busy", {62'd0, cpu_wait, busy}, 64'd0);
      check("rst_flags", {60'd0, dut.r_loaded, dut.r_dirty, dut.r_remount, 1'b0}, 64'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk_sys);
      check("no_image_idle", {63'd0, busy}, 64'd0);

      // Mount, then image becomes available: load of track 0.
      img_mounted = 1'b1;
      @(negedge clk_sys);
      img_mounted = 1'b0;
      push_track(1'b0, 0, 13);
      img_size = 64'd143360;
      wait_done(1'b0, 1'b1, "mount_load");
      check("mount_remount_clr", {63'd0, dut.r_remount}, 64'd0);

      goto_track(6'd3, "load_t3");
      goto_track(6'd4, "load_t4");
      goto_track(6'd3, "reload_t3");

      // Dirty track 3 then move to 5: flush 39..51, load 65..77.
      track_we = 1'b1;
      @(negedge clk_sys);
      track_we = 1'b0;
      check("dirty_set", {63'd0, dut.r_dirty}, 64'd1);
      push_track(1'b1, 39, 13);
      push_track(1'b0, 65, 13);
      track = 6'd5;
      wait_done(1'b1, 1'b1, "flush_load");
      check("flush_dirty_clr", {63'd0, dut.r_dirty}, 64'd0);

      // Same with a write-protected image: discard instead of flush.
      goto_track(6'd3, "back_t3");
      img_readonly = 1'b1;
      track_we = 1'b1;
      @(negedge clk_sys);
      track_we = 1'b0;
      push_track(1'b0, 65, 13);
      track = 6'd5;
      wait_done(1'b0, 1'b1, "ro_load");
      check("ro_dirty_clr", {63'd0, dut.r_dirty}, 64'd0);
      img_readonly = 1'b0;

      // Mount during the 6th sector: finish, one idle cycle, reload track 3.
      push_track(1'b0, 39, 13);
      push_track(1'b0, 39, 13);
      track = 6'd3;
      fork
         wait_done(1'b0, 1'b0, "mid_mount_a");
         begin
            n = 0;
            while (!(sd_ack && track_sec == 4'd5) && n < 1000) begin
               @(negedge clk_sys);
               n++;
            end
            img_mounted = 1'b1;
            track_we = 1'b1;
            @(negedge clk_sys);
            img_mounted = 1'b0;
            track_we = 1'b0;
         end
      join
      check("mid_mount_q_left", 64'(sb.size()), 64'd13);
      @(negedge clk_sys);
      check("mid_mount_idle_gap", {63'd0, busy}, 64'd1);
      wait_done(1'b0, 1'b1, "mid_mount_b");
      check("mid_mount_dirty", {63'd0, dut.r_dirty}, 64'd0);
      check("mid_mount_remount", {63'd0, dut.r_remount}, 64'd0);

      // Reset while loading track 7 in the 3rd sector.
      push_track(1'b0, 91, 3);
      track = 6'd7;
      n = 0;
      while (!(sd_ack && track_sec == 4'd2) && n < 1000) begin
         @(negedge clk_sys);
         n++;
      end
      @(negedge clk_sys);
      check("pre_reset_rd", {63'd0, sd_rd}, 64'd1);
      reset = 1'b1;
      #1;
      check("async_rst_req", {62'd0, sd_rd, sd_wr}, 64'd0);
      check("async_rst_wait_busy", {62'd0, cpu_wait, busy}, 64'd0);
      check("async_rst_pos", {28'd0, sd_lba, track_sec}, 64'd0);
      check("async_rst_sb", 64'(sb.size()), 64'd0);
      repeat (10) @(negedge clk_sys);
      push_track(1'b0, 91, 13);
      reset = 1'b0;
      wait_done(1'b0, 1'b1, "post_reset_load");

      repeat (5) @(negedge clk_sys);
      check("final_idle", {63'd0, busy}, 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
